// File: rtl/aes_pkg.sv
// Shared AES types and helpers: round count, GF(2^8) arithmetic, the 4x32 row
// array and the byte-order conversions between 128-bit blocks and row words.
package aes_pkg;

  localparam int NR_AES128 = 10;

  // rows[r][8c+7:8c] holds state byte s[r][c]
  typedef logic [3:0][31:0] rows_t;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) product built from repeated xtime
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Block byte n (MSB first) lands in row n%4, column n/4
  function automatic rows_t block_to_rows(input logic [127:0] blk);
    rows_t rw;
    rw = '0;
    for (int n = 0; n < 16; n++) begin
      rw[n % 4][8*(n / 4) +: 8] = blk[127 - 8*n -: 8];
    end
    return rw;
  endfunction

  function automatic logic [127:0] rows_to_block(input rows_t rw);
    logic [127:0] blk;
    blk = '0;
    for (int n = 0; n < 16; n++) begin
      blk[127 - 8*n -: 8] = rw[n % 4][8*(n / 4) +: 8];
    end
    return blk;
  endfunction

endpackage

// File: rtl/aes_mix_columns.sv
// MixColumns: each state column is multiplied by the circulant matrix
// {02 03 01 01} over GF(2^8). Column c is byte c of every row word.
module aes_mix_columns
  import aes_pkg::*;
(
  input  rows_t rows_in,
  output rows_t rows_out
);

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = rows_in[0][8*c +: 8];
    assign a1 = rows_in[1][8*c +: 8];
    assign a2 = rows_in[2][8*c +: 8];
    assign a3 = rows_in[3][8*c +: 8];

    assign rows_out[0][8*c +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign rows_out[1][8*c +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign rows_out[2][8*c +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign rows_out[3][8*c +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

endmodule

// File: rtl/aes_sub_bytes.sv
// SubBytes stage: applies the AES S-box to all sixteen state bytes,
// one 32-bit row word per port. Purely combinational.
module aes_sub_bytes
  import aes_pkg::*;
(
  input  logic [31:0] state0,
  input  logic [31:0] state1,
  input  logic [31:0] state2,
  input  logic [31:0] state3,
  output logic [31:0] subed0,
  output logic [31:0] subed1,
  output logic [31:0] subed2,
  output logic [31:0] subed3
);

  // S-box = affine transform of the multiplicative inverse; the inverse is
  // x^254, which also maps 0 to 0 without a special case.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^
           {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign subed0[8*b +: 8] = sbox(state0[8*b +: 8]);
    assign subed1[8*b +: 8] = sbox(state1[8*b +: 8]);
    assign subed2[8*b +: 8] = sbox(state2[8*b +: 8]);
    assign subed3[8*b +: 8] = sbox(state3[8*b +: 8]);
  end

endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES-128 encryption engine: one full round per clock on four
// row registers, round keys fetched combinationally by index from outside.
module aes_round_engine
  import aes_pkg::*;
#(
  parameter int NR      = NR_AES128,
  parameter int RKIDX_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       in_block,
  output logic [RKIDX_W-1:0] rk_idx,
  input  logic [127:0]       rk_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_block
);

  localparam logic [RKIDX_W-1:0] LAST_RND = RKIDX_W'(NR);

  state_t             state, state_next;
  logic [RKIDX_W-1:0] rnd, rnd_next;
  rows_t              rows, rows_next;
  rows_t              sub_rows, shift_rows, mix_rows, rk_rows, round_rows;

  assign rk_rows = block_to_rows(rk_in);

  aes_sub_bytes u_sub_bytes (
    .state0 (rows[0]),
    .state1 (rows[1]),
    .state2 (rows[2]),
    .state3 (rows[3]),
    .subed0 (sub_rows[0]),
    .subed1 (sub_rows[1]),
    .subed2 (sub_rows[2]),
    .subed3 (sub_rows[3])
  );

  // ShiftRows: row r rotates so that new column c takes old column c+r
  assign shift_rows[0] = sub_rows[0];
  for (genvar r = 1; r < 4; r++) begin : g_shift
    assign shift_rows[r] = {sub_rows[r][8*r-1:0], sub_rows[r][31:8*r]};
  end

  aes_mix_columns u_mix_columns (
    .rows_in  (shift_rows),
    .rows_out (mix_rows)
  );

  // The final round skips MixColumns
  assign round_rows = ((rnd == LAST_RND) ? shift_rows : mix_rows) ^ rk_rows;

  // State, round counter and row registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rnd   <= '0;
      rows  <= '0;
    end else begin
      state <= state_next;
      rnd   <= rnd_next;
      rows  <= rows_next;
    end
  end

  // Next-state, datapath select and handshake outputs. in_ready is also held
  // low while rst_n is low so nothing is accepted during reset.
  always_comb begin
    state_next = state;
    rnd_next   = rnd;
    rows_next  = rows;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_block  = '0;
    rk_idx     = '0;
    case (state)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid) begin
          rows_next  = block_to_rows(in_block) ^ rk_rows;
          rnd_next   = RKIDX_W'(1);
          state_next = ROUND;
        end
      end
      ROUND: begin
        rk_idx    = rnd;
        rows_next = round_rows;
        rnd_next  = rnd + RKIDX_W'(1);
        if (rnd == LAST_RND) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        out_block = rows_to_block(rows);
        if (out_ready) begin
          rnd_next   = '0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_round_engine.sv
// Bench for aes_round_engine: byte-array AES model with its own S-box and key
// expansion, a per-cycle scoreboard monitor, and directed FIPS-197 vectors.
module tb_aes_round_engine;

  localparam int NR      = 10;
  localparam int RKIDX_W = 4;

  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] R1_B  = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] RK10B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [127:0]       in_block = '0;
  logic [RKIDX_W-1:0] rk_idx;
  logic [127:0]       rk_in;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [127:0]       out_block;

  always #5 clk = ~clk;

  aes_round_engine #(.NR(NR), .RKIDX_W(RKIDX_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .rk_idx    (rk_idx),
    .rk_in     (rk_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]   sb [256];
  logic [127:0] rk_a [11];
  logic [127:0] rk_c [11];
  logic         key_sel = 1'b0;

  // External key store: combinational lookup of the selected key schedule
  assign rk_in = (rk_idx > RKIDX_W'(NR)) ? '0 :
                 (key_sel ? rk_c[rk_idx] : rk_a[rk_idx]);

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Carry-less product then polynomial reduction
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = '0;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
    return prod[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, cst;
    cst = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
      sb[x] = s;
    end
  endtask

  function automatic logic [127:0] round_key(input logic [127:0] key, input int idx);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rcon, 24'h0};
        rcon = m_mul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
  endfunction

  // State after `nrounds` rounds; bytes in FIPS order, byte n = s[n%4][n/4]
  function automatic logic [127:0] model_enc(input logic [127:0] pt, input logic kc, input int nrounds);
    logic [127:0] s, t;
    logic [7:0]   a0, a1, a2, a3;
    s = pt ^ (kc ? rk_c[0] : rk_a[0]);
    for (int rd = 1; rd <= nrounds; rd++) begin
      for (int n = 0; n < 16; n++) t[127 - 8*n -: 8] = sb[s[127 - 8*n -: 8]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          s[127 - 8*(r + 4*c) -: 8] = t[127 - 8*(r + 4*((c + r) % 4)) -: 8];
      if (rd < NR) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[127 - 8*(4*c) -: 8];
          a1 = s[127 - 8*(4*c+1) -: 8];
          a2 = s[127 - 8*(4*c+2) -: 8];
          a3 = s[127 - 8*(4*c+3) -: 8];
          s[127 - 8*(4*c)   -: 8] = m_mul(a0, 8'h02) ^ m_mul(a1, 8'h03) ^ a2 ^ a3;
          s[127 - 8*(4*c+1) -: 8] = a0 ^ m_mul(a1, 8'h02) ^ m_mul(a2, 8'h03) ^ a3;
          s[127 - 8*(4*c+2) -: 8] = a0 ^ a1 ^ m_mul(a2, 8'h02) ^ m_mul(a3, 8'h03);
          s[127 - 8*(4*c+3) -: 8] = m_mul(a0, 8'h03) ^ a1 ^ a2 ^ m_mul(a3, 8'h02);
        end
      end
      s = s ^ (kc ? rk_c[rd] : rk_a[rd]);
    end
    return s;
  endfunction

  function automatic logic [127:0] rows_blk(input logic [3:0][31:0] rr);
    logic [127:0] b;
    for (int n = 0; n < 16; n++) b[127 - 8*n -: 8] = rr[n % 4][8*(n / 4) +: 8];
    return b;
  endfunction

  // ---------------- scoreboard monitor ----------------
  int           cyc = 0;
  logic         rst_q = 1'b0;
  logic [127:0] exp_q [$];
  int           acc_q [$];

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst_n;
  end

  always @(negedge clk) begin
    logic exp_ov;
    if (!rst_q) begin
      exp_q.delete();
      acc_q.delete();
    end
    if (!rst_n) begin
      chk("rst_in_ready", 128'(in_ready), 128'(0));
      if (!rst_q) begin
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_rk_idx", 128'(rk_idx), 128'(0));
        chk("rst_out_block", out_block, 128'(0));
      end
    end else begin
      exp_ov = (exp_q.size() != 0) && ((cyc - acc_q[0]) >= NR + 1);
      chk("mon_in_ready", 128'(in_ready), 128'(exp_q.size() == 0));
      chk("mon_out_valid", 128'(out_valid), 128'(exp_ov));
      if (exp_q.size() == 0 || exp_ov) chk("mon_rk_idx_zero", 128'(rk_idx), 128'(0));
      else chk("mon_rk_idx", 128'(rk_idx), 128'(cyc - acc_q[0]));
      if (exp_ov && out_valid) begin
        chk("mon_out_block", out_block, exp_q[0]);
        if (out_ready) begin
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model_enc(in_block, key_sel, NR));
        acc_q.push_back(cyc);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_out_valid(input int maxc, output int at);
    at = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (out_valid) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_out_valid: got none within %0d cycles", maxc);
    end
  endtask

  initial begin
    int t1, t2, tr;
    logic [3:0][31:0] rr;

    build_sbox();
    for (int i = 0; i <= NR; i++) begin
      rk_a[i] = round_key(KEY_B, i);
      rk_c[i] = round_key(KEY_C, i);
    end

    // Pin the model to published values
    chk("model_sbox_00", 128'(sb[8'h00]), 128'h63);
    chk("model_sbox_53", 128'(sb[8'h53]), 128'hed);
    chk("model_rk10_b", rk_a[10], RK10B);
    chk("model_round1_b", model_enc(PT_B, 1'b0, 1), R1_B);
    chk("model_ct_b", model_enc(PT_B, 1'b0, NR), CT_B);
    chk("model_ct_c", model_enc(PT_C, 1'b1, NR), CT_C);

    // Reset
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", 128'(in_ready), 128'(0));
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_out_block", out_block, 128'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 128'(in_ready), 128'(1));

    // App.B with round-key index trace and round-1 state
    @(posedge clk); #1;
    key_sel = 1'b0; in_block = PT_B; in_valid = 1'b1;
    @(negedge clk);
    chk("trace_accept_ready", 128'(in_ready), 128'(1));
    chk("trace_rk_idx_0", 128'(rk_idx), 128'(0));
    @(posedge clk); #1 in_valid = 1'b0;
    for (int k = 1; k <= NR; k++) begin
      @(negedge clk);
      chk($sformatf("trace_rk_idx_%0d", k), 128'(rk_idx), 128'(k));
      if (k == 2) begin
        rr = dut.rows;
        chk("round1_state_b", rows_blk(rr), R1_B);
      end
    end
    @(negedge clk);
    chk("ct_b_valid_t11", 128'(out_valid), 128'(1));
    chk("ct_b", out_block, CT_B);

    // App.C.1 with 20 cycles of backpressure and ignored in_valid pulses
    @(posedge clk); #1;
    key_sel = 1'b1; in_block = PT_C; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 in_valid = 1'b0;
    wait_out_valid(20, tr);
    chk("ct_c", out_block, CT_C);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      in_valid = (i % 2 == 0); in_block = PT_B;
      @(negedge clk);
      chk("stall_out_valid", 128'(out_valid), 128'(1));
      chk("stall_out_block", out_block, CT_C);
      chk("stall_in_ready", 128'(in_ready), 128'(0));
    end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("release_out_valid", 128'(out_valid), 128'(1));
    @(negedge clk);
    chk("after_release_out_valid", 128'(out_valid), 128'(0));
    chk("after_release_in_ready", 128'(in_ready), 128'(1));

    // Back-to-back: in_valid held high across two blocks
    @(posedge clk); #1;
    key_sel = 1'b0; in_block = PT_B; in_valid = 1'b1; out_ready = 1'b1;
    wait_out_valid(20, t1);
    chk("b2b_ct_b", out_block, CT_B);
    @(posedge clk); #1 key_sel = 1'b1; in_block = PT_C;
    @(negedge clk);
    chk("b2b_second_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1 in_valid = 1'b0;
    wait_out_valid(20, t2);
    chk("b2b_ct_c", out_block, CT_C);
    chk("b2b_spacing", 128'(t2 - t1), 128'(NR + 2));

    // Reset during round 5 discards the block
    @(posedge clk); #1;
    key_sel = 1'b1; in_block = PT_C; in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 in_valid = 1'b0;
    tr = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rk_idx == RKIDX_W'(4)) begin
        tr = i;
        break;
      end
    end
    if (tr < 0) chk("midop_reach_round4", 128'(0), 128'(1));
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midop_idle_ready", 128'(in_ready), 128'(1));
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      chk("midop_no_out_valid", 128'(out_valid), 128'(0));
    end
    @(posedge clk); #1;
    key_sel = 1'b0; in_block = PT_B; in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 in_valid = 1'b0;
    wait_out_valid(20, tr);
    chk("midop_next_ct_b", out_block, CT_B);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
